// File: rtl/adder_psum_pkg.sv
// Shared constants, kernel-size encodings and round-decoding helpers for the
// accumulating partial-sum adder.
package adder_psum_pkg;

  localparam int NPIX = 36;   // output pixels per 6x6 tile
  localparam int TILE = 6;    // tile edge length
  localparam int NCH  = 8;    // input channels per pixel
  localparam int NTAP = 16;   // kernel taps per round
  localparam int PW   = 16;   // signed product width
  localparam int SW   = 24;   // signed partial-sum width
  localparam int TW   = 5;    // width of a tap count (0..16)

  typedef enum logic [3:0] {
    WS_3X3 = 4'd0,
    WS_5X5 = 4'd1,
    WS_7X7 = 4'd2
  } wsize_e;

  // Number of taps used in a round; zero marks an ignored (wsize,wround).
  function automatic logic [TW-1:0] tap_count(input logic [3:0] wsize,
                                              input logic [2:0] wround);
    logic [TW-1:0] n;
    n = '0;
    case (wsize)
      WS_3X3: if (wround == 3'd0) n = 5'd9;
      WS_5X5: begin
        if (wround == 3'd0)      n = 5'd16;
        else if (wround == 3'd1) n = 5'd9;
      end
      WS_7X7: begin
        if (wround <= 3'd2)      n = 5'd16;
        else if (wround == 3'd3) n = 5'd1;
      end
      default: n = '0;
    endcase
    return n;
  endfunction

  // True when this round completes the kernel.
  function automatic logic is_last(input logic [3:0] wsize,
                                   input logic [2:0] wround);
    logic l;
    l = 1'b0;
    case (wsize)
      WS_3X3:  l = (wround == 3'd0);
      WS_5X5:  l = (wround == 3'd1);
      WS_7X7:  l = (wround == 3'd3);
      default: l = 1'b0;
    endcase
    return l;
  endfunction

  // Sign-extend one product to partial-sum width.
  function automatic logic signed [SW-1:0] sext_prod(input logic signed [PW-1:0] x);
    return {{(SW-PW){x[PW-1]}}, x};
  endfunction

endpackage

// File: rtl/adder_pixel_tree.sv
// Reduces the 8x16 products of one pixel to a single signed sum, counting
// only taps below the round's tap count.
module adder_pixel_tree
  import adder_psum_pkg::*;
(
  input  logic [NCH*NTAP*PW-1:0] products,
  input  logic [TW-1:0]          ntap,
  output logic signed [SW-1:0]   sum
);

  // Masked reduction; 128 * 2^15 fits well inside SW bits so no overflow here.
  always_comb begin
    sum = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int t = 0; t < NTAP; t++) begin
        if (TW'(t) < ntap)
          sum = sum + sext_prod(products[(c*NTAP+t)*PW +: PW]);
      end
    end
  end

endmodule

// File: rtl/adder_psum.sv
// Accumulating adder-tree stage: per-round pixel reduction (stage 1),
// cross-round accumulation and tile output (stage 2).
module adder_psum
  import adder_psum_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,   // active-high despite the name
  input  logic [3:0]                  wsize,
  input  logic                        stride,
  input  logic [2:0]                  wround,
  input  logic [NPIX*NCH*NTAP*PW-1:0] MUL_results,
  input  logic                        MUL_DATA_valid,
  output logic                        Psum_valid,
  output logic [NPIX*SW-1:0]          Psum
);

  // Accumulation wraps modulo 2^SW.
  function automatic logic signed [SW-1:0] wrap_add(input logic signed [SW-1:0] a,
                                                    input logic signed [SW-1:0] b);
    return a + b;
  endfunction

  logic [TW-1:0] ntap_p0;
  logic          accept_p0;
  logic          vld_p1, first_p1, last_p1, stride_p1;

  assign ntap_p0   = tap_count(wsize, wround);
  assign accept_p0 = MUL_DATA_valid && (ntap_p0 != '0);

  // ---- stage 1: round control flags ----
  // Capture per-round flags alongside the pixel sums.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
      stride_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept_p0;
      if (accept_p0) begin
        first_p1  <= (wround == 3'd0);
        last_p1   <= is_last(wsize, wround);
        stride_p1 <= stride;
      end
    end
  end

  // ---- stage 2: output strobe ----
  // One-cycle strobe when the final round of a kernel is accumulated.
  always_ff @(posedge clk) begin
    if (rst_n) Psum_valid <= 1'b0;
    else       Psum_valid <= vld_p1 && last_p1;
  end

  for (genvar p = 0; p < NPIX; p++) begin : g_pix
    localparam bit KEEP = (((p / TILE) % 2) == 0) && (((p % TILE) % 2) == 0);

    logic signed [SW-1:0] tree_sum, sum_p1, acc_p2, acc_next, psum_p2;

    adder_pixel_tree u_tree (
      .products (MUL_results[p*NCH*NTAP*PW +: NCH*NTAP*PW]),
      .ntap     (ntap_p0),
      .sum      (tree_sum)
    );

    assign acc_next = first_p1 ? sum_p1 : wrap_add(acc_p2, sum_p1);

    // ---- stage 1: pixel round sum ----
    // Register the masked round sum for this pixel.
    always_ff @(posedge clk) begin
      if (rst_n)          sum_p1 <= '0;
      else if (accept_p0) sum_p1 <= tree_sum;
    end

    // ---- stage 2: accumulate and publish ----
    // Accumulate rounds; on the last round publish, zeroing skipped pixels for stride 2.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        acc_p2  <= '0;
        psum_p2 <= '0;
      end else if (vld_p1) begin
        acc_p2 <= acc_next;
        if (last_p1)
          psum_p2 <= (stride_p1 && !KEEP) ? '0 : acc_next;
      end
    end

    assign Psum[p*SW +: SW] = psum_p2;
  end

endmodule

// File: tb/tb_adder_psum.sv
// Scoreboard bench for adder_psum: stimulus pushes expected tiles, a monitor
// pops and compares them whenever Psum_valid is seen.
module tb_adder_psum;
  import adder_psum_pkg::*;

  localparam int MW = NPIX*NCH*NTAP*PW;
  localparam int OW = NPIX*SW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    wsize;
  logic          stride;
  logic [2:0]    wround;
  logic [MW-1:0] mul;
  logic          mul_valid;
  logic          Psum_valid;
  logic [OW-1:0] Psum;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [OW-1:0] exp_q[$];
  int            due_q[$];
  logic [OW-1:0] last_tile;

  adder_psum dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wsize          (wsize),
    .stride         (stride),
    .wround         (wround),
    .MUL_results    (mul),
    .MUL_DATA_valid (mul_valid),
    .Psum_valid     (Psum_valid),
    .Psum           (Psum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OW-1:0] tile_of(input logic [SW-1:0] v, input logic st);
    logic [OW-1:0] r;
    for (int p = 0; p < NPIX; p++) begin
      if (st && !((((p / 6) % 2) == 0) && (((p % 6) % 2) == 0))) r[p*SW +: SW] = '0;
      else                                                       r[p*SW +: SW] = v;
    end
    return r;
  endfunction

  function automatic logic [MW-1:0] all_prod(input logic [PW-1:0] v);
    return {(NPIX*NCH*NTAP){v}};
  endfunction

  task automatic send(input logic [3:0] ws, input logic [2:0] wr, input logic st);
    wsize = ws; wround = wr; stride = st; mul_valid = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
  endtask

  task automatic gap();
    @(posedge clk); #1;
  endtask

  task automatic expect_tile(input logic [OW-1:0] v);
    exp_q.push_back(v);
    due_q.push_back(cyc + 2);
    last_tile = v;
  endtask

  // Monitor: compare each presented tile against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_n && Psum_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid at cycle %0d", cyc);
      end else begin
        logic [OW-1:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (cyc != d) begin
          failures++;
          $display("FAIL latency got cycle %0d want cycle %0d", cyc, d);
        end
        for (int p = 0; p < NPIX; p++) begin
          checks++;
          if (Psum[p*SW +: SW] !== e[p*SW +: SW]) begin
            failures++;
            $display("FAIL pixel%0d got %h want %h", p, Psum[p*SW +: SW], e[p*SW +: SW]);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; mul_valid = 1'b0; mul = '0;
    wsize = '0; wround = '0; stride = 1'b0; last_tile = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Psum !== '0 || Psum_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got valid=%b psum_nonzero=%b want 0", Psum_valid, |Psum);
    end
    rst_n = 1'b0;
    gap();

    // 3x3, 5x5, 7x7 with all-ones products
    mul = all_prod(16'h0001);
    expect_tile(tile_of(24'd72, 1'b0));  send(4'd0, 3'd0, 1'b0);
    send(4'd1, 3'd0, 1'b0);
    expect_tile(tile_of(24'd200, 1'b0)); send(4'd1, 3'd1, 1'b0);
    send(4'd2, 3'd0, 1'b0); send(4'd2, 3'd1, 1'b0); send(4'd2, 3'd2, 1'b0);
    expect_tile(tile_of(24'd392, 1'b0)); send(4'd2, 3'd3, 1'b0);

    // negative products, stride 1 and 2
    mul = all_prod(16'hFFFF);
    expect_tile(tile_of(24'hFFFFB8, 1'b0)); send(4'd0, 3'd0, 1'b0);
    expect_tile(tile_of(24'hFFFFB8, 1'b1)); send(4'd0, 3'd0, 1'b1);

    // sequence with gap cycles between kernels
    mul = all_prod(16'h0001);
    expect_tile(tile_of(24'd72, 1'b0)); send(4'd0, 3'd0, 1'b0);
    gap();
    send(4'd1, 3'd0, 1'b0);
    expect_tile(tile_of(24'd200, 1'b0)); send(4'd1, 3'd1, 1'b0);
    gap();
    send(4'd2, 3'd0, 1'b0); send(4'd2, 3'd1, 1'b0); send(4'd2, 3'd2, 1'b0);
    expect_tile(tile_of(24'd392, 1'b0)); send(4'd2, 3'd3, 1'b0);

    // output holds across idle cycles
    repeat (4) gap();
    @(negedge clk);
    checks++;
    if (Psum !== last_tile) begin
      failures++;
      $display("FAIL hold got %h want %h", Psum[SW-1:0], last_tile[SW-1:0]);
    end
    gap();

    // ignored (reserved / out-of-list) rounds inside a 5x5 kernel
    send(4'd1, 3'd0, 1'b0);
    send(4'd3, 3'd0, 1'b0);
    send(4'd0, 3'd1, 1'b0);
    send(4'd1, 3'd5, 1'b0);
    expect_tile(tile_of(24'd200, 1'b0)); send(4'd1, 3'd1, 1'b0);

    // idle cycles between rounds of a 7x7 kernel
    send(4'd2, 3'd0, 1'b0); gap();
    send(4'd2, 3'd1, 1'b0); gap(); gap();
    send(4'd2, 3'd2, 1'b0);
    expect_tile(tile_of(24'd392, 1'b0)); send(4'd2, 3'd3, 1'b0);

    // restart mid-kernel: 7x7 abandoned, 5x5 of 0x0100 -> 25*8*256
    mul = all_prod(16'h0100);
    send(4'd2, 3'd0, 1'b0); send(4'd2, 3'd1, 1'b0);
    send(4'd1, 3'd0, 1'b0);
    expect_tile(tile_of(24'h00C800, 1'b0)); send(4'd1, 3'd1, 1'b0);

    // wrap modulo 2^24: 392 * -32768 = -12845056 -> 0x3C0000
    mul = all_prod(16'h8000);
    send(4'd2, 3'd0, 1'b0); send(4'd2, 3'd1, 1'b0); send(4'd2, 3'd2, 1'b0);
    expect_tile(tile_of(24'h3C0000, 1'b0)); send(4'd2, 3'd3, 1'b0);

    // per-pixel data: pixel p products = p+1 -> 72*(p+1)
    begin
      logic [OW-1:0] e;
      for (int p = 0; p < NPIX; p++) begin
        for (int k = 0; k < NCH*NTAP; k++) mul[(p*NCH*NTAP+k)*PW +: PW] = 16'(p + 1);
        e[p*SW +: SW] = 24'(72 * (p + 1));
      end
      expect_tile(e); send(4'd0, 3'd0, 1'b0);
    end

    // tap-dependent data: product = t+1 -> 3x3: 8*45, 5x5: 8*136 + 8*45
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < NCH; c++)
        for (int t = 0; t < NTAP; t++)
          mul[((p*NCH+c)*NTAP+t)*PW +: PW] = 16'(t + 1);
    expect_tile(tile_of(24'd360, 1'b0)); send(4'd0, 3'd0, 1'b0);
    send(4'd1, 3'd0, 1'b0);
    expect_tile(tile_of(24'd1448, 1'b0)); send(4'd1, 3'd1, 1'b0);
    // 7x7 round 3 uses only tap 0: 3*8*136 + 8*1
    send(4'd2, 3'd0, 1'b0); send(4'd2, 3'd1, 1'b0); send(4'd2, 3'd2, 1'b0);
    expect_tile(tile_of(24'd3272, 1'b0)); send(4'd2, 3'd3, 1'b0);
    repeat (3) gap();

    // reset mid-kernel, including a last round still in flight
    mul = all_prod(16'h0001);
    send(4'd1, 3'd0, 1'b0);
    send(4'd0, 3'd0, 1'b0);
    rst_n = 1'b1;
    gap(); gap();
    @(negedge clk);
    checks++;
    if (Psum !== '0 || Psum_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_clear got valid=%b pix0=%h want 0", Psum_valid, Psum[SW-1:0]);
    end
    rst_n = 1'b0;
    gap(); gap();
    @(negedge clk);
    checks++;
    if (Psum !== '0 || Psum_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got valid=%b pix0=%h want 0", Psum_valid, Psum[SW-1:0]);
    end
    gap();
    send(4'd1, 3'd0, 1'b0);
    expect_tile(tile_of(24'd200, 1'b0)); send(4'd1, 3'd1, 1'b0);

    repeat (6) gap();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_tiles got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_psum.md
Name: adder_psum

Overview:
- Accumulating adder-tree stage that sits between the multiplier array and the partial-sum buffer of the convolution engine.
- Each valid cycle it reduces one round of signed 16-bit products into 36 per-pixel sums for a 6x6 output tile.
- It accumulates across the rounds that 5x5 and 7x7 kernels need, then presents the 36 finished 24-bit partial sums with a one-cycle valid strobe.

Parameters:
- NPIX, 36, output pixels per tile (6x6, pixel p = row*6+col).
- NCH, 8, input channels per pixel.
- NTAP, 16, kernel taps per round.
- PW, 16, product width (signed).
- SW, 24, partial-sum width (signed).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, ACTIVE-HIGH; the name is kept for codebase consistency.
- wsize  in  4  kernel size: 0=3x3, 1=5x5, 2=7x7, 3..15 reserved.
- stride  in  1  0=stride 1, 1=stride 2.
- wround  in  3  round index within the current kernel.
- MUL_results  in  73728  products; product (p,c,t) at bit offset ((p*8+c)*16+t)*16, 16 bits, signed.
- MUL_DATA_valid  in  1  qualifies MUL_results, wsize, wround and stride for this cycle.
- Psum_valid  out  1  one-cycle strobe: Psum holds a finished tile.
- Psum  out  864  pixel p signed sum at bits [p*24 +: 24].

Behaviour:
- Reset values: Psum=0, Psum_valid=0, accumulators=0, stage-1 valid=0.
- Tap mask per round (masked products count as 0):
  - wsize0: round0 uses t<9.
  - wsize1: round0 uses t<16; round1 uses t<9 (25 taps total).
  - wsize2: rounds 0..2 use t<16; round3 uses t<1 (49 taps total).
- Last round: (wsize0,wround0), (wsize1,wround1), (wsize2,wround3).
- Ignored inputs: any (wsize,wround) outside these lists, and any reserved wsize, are ignored. Such a cycle does not change accumulators and produces no valid.
- Stage 1 (registered at the edge sampling MUL_DATA_valid=1):
  - per pixel, sum the 8x16 masked products sign-extended to 24 bits.
  - latch the first flag (wround==0), the last flag, and stride.
- Stage 2 (next edge):
  - if first: acc = stage1 sum; otherwise acc = acc + stage1 sum.
  - arithmetic wraps modulo 2^24, with no saturation.
- Output on last:
  - Psum = new acc, Psum_valid=1 for exactly one cycle.
  - stride=1 forces pixels with odd row or odd col to 0 in Psum; 9 pixels remain, at rows/cols 0,2,4.
- Latency: a last-round input sampled at edge k gives Psum_valid high after edge k+1 (2-cycle latency).
- Throughput: one round per cycle, back-to-back, with no bubbles required between kernels.
- Psum holds its value until the next output or reset.
- wround==0 arriving mid-kernel discards the old accumulation and restarts.
- Idle cycles (MUL_DATA_valid=0) between rounds keep the accumulators unchanged.
- Reset mid-kernel clears everything; in-flight rounds are lost and no valid is produced.

Decomposition:
- Shared package holds:
  - NPIX/NCH/NTAP/PW/SW;
  - the wsize encodings;
  - a function returning the tap count for (wsize,wround);
  - a function returning the last-round flag.
- One sub-module, adder_pixel_tree: reduces 128 masked signed products to one 24-bit sum. It is instantiated 36 times.

Test Plan:
- All products = 16'h0001, wsize0 wround0, one valid cycle -> 2 cycles later Psum_valid=1 for 1 cycle; every pixel = 72.
- All products = 1, wsize1, wround 0 then 1 on consecutive cycles -> one valid only; every pixel = 200 (128+72).
- All products = 1, wsize2, wround 0..3 consecutive -> one valid; every pixel = 392.
- All products = 16'hFFFF, wsize0 -> every pixel = 24'hFFFFB8 (-72). Same data with stride=1 -> even-row/even-col pixels 24'hFFFFB8, all others 0.
- Sequence 3x3, gap cycle, 5x5, gap cycle, 7x7 (all-ones data) -> exactly three valid pulses carrying 72, 200, 392.
- Reset asserted after wsize1 round0 -> Psum=0, no valid. Restart with wround0 and wround1 -> 200.
